uart_frame_tx: RTL and testbench

- Transmit-side packetizer between user logic and the uart_drive TX handshake (data / valid / ready).
- Collects one payload of 1..P_MAX_LEN bytes from a valid/ready stream into an internal buffer.
- Then emits one framed packet, byte by byte: header 0x55, header 0xAA, length, payload, checksum.
- Counterpart of the RX-side frame parser; runs entirely in the w_user_clk domain.

---
 rtl/uart_frame_tx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffers one payload from a valid/ready stream, then sends it to
// uart_drive as a frame: HDR0, HDR1, length, payload bytes, checksum.
// Checksum is the mod-256 sum of the length byte and the stored payload bytes.

module uart_frame_tx #(
    parameter int unsigned                P_DATA_WIDTH = 8,
    parameter int unsigned                P_MAX_LEN    = 64,
    parameter logic [P_DATA_WIDTH-1:0]    P_HDR0       = 8'h55,
    parameter logic [P_DATA_WIDTH-1:0]    P_HDR1       = 8'hAA
) (
    input  logic                    w_user_clk,
    input  logic                    w_user_rst,
    input  logic [P_DATA_WIDTH-1:0] i_pl_data,
    input  logic                    i_pl_valid,
    input  logic                    i_pl_last,
    output logic                    o_pl_ready,
    output logic [P_DATA_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_len_err
);

    localparam int unsigned AW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;

    typedef logic [P_DATA_WIDTH-1:0] data_t;

    localparam data_t MaxLen = data_t'(P_MAX_LEN);

    typedef enum logic [2:0] {
        StLoad, StHdr0, StHdr1, StLen, StPayload, StCsum, StDone
    } state_e;

    state_e state_q, state_d, adv_state;
    data_t  wr_ptr_q, wr_ptr_d;
    data_t  rd_ptr_q, rd_ptr_d, adv_rd;
    data_t  sum_q, sum_d;
    data_t  tx_data_q, tx_data_d, tx_byte;
    logic   pl_ready_q, pl_ready_d;
    logic   len_err_q, len_err_d;
    logic   tx_valid_q, tx_valid_d;
    logic   outstanding_q, outstanding_d;
    logic   seen_low_q, seen_low_d;
    logic   frame_done_q, frame_done_d;
    logic   busy_q, busy_d;
    logic   mem_we;
    logic   tx_complete;
    data_t  mem_q [P_MAX_LEN];

    // Issued byte has finished once ready was seen low and is now high again.
    assign tx_complete = outstanding_q && seen_low_q && i_tx_ready;

    // Where the FSM goes when the outstanding byte completes this cycle.
    always_comb begin
        adv_state = state_q;
        adv_rd    = rd_ptr_q;
        if (tx_complete) begin
            unique case (state_q)
                StHdr0:    adv_state = StHdr1;
                StHdr1:    adv_state = StLen;
                StLen:     adv_state = StPayload;
                StPayload: begin
                    if (rd_ptr_q == wr_ptr_q - 1'b1) begin
                        adv_state = StCsum;
                        adv_rd    = '0;
                    end else begin
                        adv_rd = rd_ptr_q + 1'b1;
                    end
                end
                StCsum:    adv_state = StDone;
                default:   adv_state = state_q;
            endcase
        end
    end

    // Byte to issue for the state the FSM is in (or about to enter).
    always_comb begin
        case (adv_state)
            StHdr0:    tx_byte = P_HDR0;
            StHdr1:    tx_byte = P_HDR1;
            StLen:     tx_byte = wr_ptr_q;
            StPayload: tx_byte = mem_q[adv_rd[AW-1:0]];
            StCsum:    tx_byte = sum_q + wr_ptr_q;
            default:   tx_byte = tx_data_q;
        endcase
    end

    // Next-state logic: payload collection in LOAD, per-byte issue/complete elsewhere.
    always_comb begin
        state_d       = state_q;
        pl_ready_d    = pl_ready_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        sum_d         = sum_q;
        len_err_d     = len_err_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        outstanding_d = outstanding_q;
        seen_low_d    = seen_low_q;
        frame_done_d  = 1'b0;
        mem_we        = 1'b0;

        unique case (state_q)
            StLoad: begin
                pl_ready_d = 1'b1;
                if (i_pl_valid && pl_ready_q) begin
                    if (wr_ptr_q == '0) begin
                        len_err_d = 1'b0;
                    end
                    if (wr_ptr_q < MaxLen) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        sum_d    = sum_q + i_pl_data;
                    end else begin
                        // Overflow: drop the byte, keep accepting until last.
                        len_err_d = 1'b1;
                    end
                    if (i_pl_last) begin
                        pl_ready_d = 1'b0;
                        state_d    = StHdr0;
                    end
                end
            end
            StDone: begin
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                sum_d      = '0;
                pl_ready_d = 1'b1;
                state_d    = StLoad;
            end
            default: begin
                if (outstanding_q && !i_tx_ready) begin
                    seen_low_d = 1'b1;
                end
                if (tx_complete) begin
                    outstanding_d = 1'b0;
                    state_d       = adv_state;
                    rd_ptr_d      = adv_rd;
                    if (adv_state == StDone) begin
                        frame_done_d = 1'b1;
                    end
                end
                // Completion and the next issue may share a cycle; ready is already high.
                if ((!outstanding_q || tx_complete) && i_tx_ready && (adv_state != StDone)) begin
                    tx_valid_d    = 1'b1;
                    tx_data_d     = tx_byte;
                    outstanding_d = 1'b1;
                    seen_low_d    = 1'b0;
                end
            end
        endcase

        busy_d = (state_d != StLoad);
    end

    // Control and output registers; reset aborts any frame in progress.
    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            state_q       <= StLoad;
            pl_ready_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sum_q         <= '0;
            len_err_q     <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            outstanding_q <= 1'b0;
            seen_low_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pl_ready_q    <= pl_ready_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sum_q         <= sum_d;
            len_err_q     <= len_err_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            outstanding_q <= outstanding_d;
            seen_low_q    <= seen_low_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    // Payload buffer; contents are only meaningful up to wr_ptr_q, so no reset.
    always_ff @(posedge w_user_clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_pl_data;
        end
    end

    assign o_pl_ready   = pl_ready_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;
    assign o_len_err    = len_err_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: a uart_drive model answers each issued byte, a queue
// of expected frame bytes is filled when payload is driven and drained on o_tx_valid.

module tb_uart_frame_tx;

    localparam int MaxLen  = 4;
    localparam int Timeout = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pl_data = 8'h00;
    logic       pl_valid = 1'b0;
    logic       pl_last = 1'b0;
    logic       pl_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;
    logic       len_err;

    logic       drv_ready = 1'b1;
    int         drv_cnt = 0;
    int         ser_cycles = 3;
    logic       stall = 1'b0;

    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         tx_seen = 0;
    int         done_cnt = 0;
    int         sent_cnt = 0;
    int         abort_cnt = 0;
    logic       gate_viol = 1'b0;
    logic       long_pulse = 1'b0;
    logic       done_prev = 1'b0;

    always #5 clk = ~clk;

    assign tx_ready = drv_ready && !stall;

    uart_frame_tx #(
        .P_DATA_WIDTH (8),
        .P_MAX_LEN    (MaxLen),
        .P_HDR0       (8'h55),
        .P_HDR1       (8'hAA)
    ) dut (
        .w_user_clk   (clk),
        .w_user_rst   (rst),
        .i_pl_data    (pl_data),
        .i_pl_valid   (pl_valid),
        .i_pl_last    (pl_last),
        .o_pl_ready   (pl_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_len_err    (len_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // uart_drive model: busy for a few cycles after each issue pulse.
    always @(posedge clk) begin
        if (tx_valid) begin
            drv_ready <= 1'b0;
            drv_cnt   <= ser_cycles;
        end else if (!drv_ready) begin
            if (drv_cnt == 0) drv_ready <= 1'b1;
            else drv_cnt <= drv_cnt - 1;
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (tx_valid) begin
            tx_seen++;
            check("issue_while_busy", int'(drv_ready), 1);
            if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
            else check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
        if (pl_ready && (sent_cnt > done_cnt + abort_cnt)) gate_viol = 1'b1;
        if (frame_done) begin
            if (done_prev) long_pulse = 1'b1;
            done_cnt++;
        end
        done_prev = frame_done;
    end

    task automatic push_frame(input logic [7:0] base, input int n);
        int         len;
        logic [7:0] sum;
        len = (n > MaxLen) ? MaxLen : n;
        sum = 8'(len);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(base + 8'(i));
            sum = sum + base + 8'(i);
        end
        exp_q.push_back(sum);
    endtask

    task automatic send_frame(input logic [7:0] base, input int n, input bit chk_clear);
        int guard;
        push_frame(base, n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 1 && chk_clear) check("len_err_clear", int'(len_err), 0);
            pl_data  = base + 8'(i);
            pl_valid = 1'b1;
            pl_last  = (i == n - 1);
            guard    = 0;
            while (!pl_ready && guard < Timeout) begin
                @(negedge clk);
                guard++;
            end
            if (!pl_ready) begin
                check("accept_timeout", guard, 0);
                pl_valid = 1'b0;
                pl_last  = 1'b0;
                return;
            end
            @(posedge clk);
        end
        sent_cnt++;
        @(negedge clk);
        if (chk_clear && n == 1) check("len_err_clear", int'(len_err), 0);
        pl_valid = 1'b0;
        pl_last  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int guard = 0;
        while (done_cnt < target && guard < Timeout) begin
            @(negedge clk);
            guard++;
        end
        check("frame_done_count", done_cnt, target);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pl_ready"}, int'(pl_ready), 0);
        check({tag, "_tx_valid"}, int'(tx_valid), 0);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_len_err"}, int'(len_err), 0);
    endtask

    initial begin
        int base_seen;
        int guard;
        int n_valid;
        int n_change;

        rst = 1'b1;
        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_rel_0", int'(pl_ready), 0);
        @(negedge clk);
        check("ready_rel_1", int'(pl_ready), 1);

        // Basic 3-byte frame.
        send_frame(8'h01, 3, 1'b0);
        wait_frames(1);
        check("no_len_err", int'(len_err), 0);

        // Overflow: 6 bytes into a 4-byte buffer.
        send_frame(8'h10, 6, 1'b0);
        check("len_err_set", int'(len_err), 1);
        wait_frames(2);
        check("len_err_sticky", int'(len_err), 1);

        // Single byte, checksum wraps.
        send_frame(8'hFF, 1, 1'b1);
        wait_frames(3);

        // Stall uart_drive ready for 100 cycles while HDR1 is outstanding.
        send_frame(8'h30, 2, 1'b0);
        guard = 0;
        while (!(tx_valid && tx_data == 8'hAA) && guard < Timeout) begin
            @(negedge clk);
            guard++;
        end
        check("hdr1_seen", int'(guard < Timeout), 1);
        stall    = 1'b1;
        n_valid  = 0;
        n_change = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_valid) n_valid++;
            if (tx_data != 8'hAA) n_change++;
        end
        check("stall_no_valid", n_valid, 0);
        check("stall_data_held", n_change, 0);
        check("stall_busy", int'(busy), 1);
        stall = 1'b0;
        @(negedge clk);
        check("len_after_stall", int'(tx_valid), 1);
        wait_frames(4);

        // Reset while payload byte 2 of a 5-byte frame is being serialised.
        base_seen = tx_seen;
        send_frame(8'h21, 5, 1'b0);
        guard = 0;
        while (tx_seen < base_seen + 5 && guard < Timeout) begin
            @(negedge clk);
            guard++;
        end
        check("payload2_seen", int'(tx_data), 8'h22);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        exp_q.delete();
        abort_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_rel2_0", int'(pl_ready), 0);
        @(negedge clk);
        check("ready_rel2_1", int'(pl_ready), 1);
        send_frame(8'h05, 3, 1'b0);
        wait_frames(5);

        // Back-to-back: overflowing frame, then a second frame offered during its transmission.
        send_frame(8'h40, 6, 1'b0);
        check("len_err_a", int'(len_err), 1);
        send_frame(8'h7E, 2, 1'b1);
        wait_frames(7);
        check("ready_gated", int'(gate_viol), 0);
        check("done_single_cycle", int'(long_pulse), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
